// File: rtl/cordic_prerotate_pkg.sv
// Shared widths, constants, encodings and sign-magnitude helpers for the cordic front end.
package cordic_prerotate_pkg;

  localparam int unsigned W     = 16;
  localparam int unsigned FRAC  = 11;
  localparam int unsigned MAG_W = W - 1;

  localparam logic [W-1:0] HALF_PI = 16'd3217;
  localparam logic [W-1:0] PI      = 16'd6434;

  localparam logic [MAG_W-1:0] HALF_PI_MAG = HALF_PI[MAG_W-1:0];
  localparam logic [MAG_W-1:0] PI_MAG      = PI[MAG_W-1:0];

  typedef enum logic {
    MODE_ROT = 1'b0,
    MODE_VEC = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    ROT_NONE  = 2'b00,
    ROT_POS90 = 2'b01,
    ROT_NEG90 = 2'b10
  } rot_e;

  // Sign-magnitude operand: bit W-1 is the sign, the rest the magnitude.
  typedef struct packed {
    logic             sign;
    logic [MAG_W-1:0] mag;
  } sm_t;

  localparam sm_t HALF_PI_SM = '{sign: 1'b0, mag: HALF_PI_MAG};

  // Clear the sign of a zero magnitude so -0 never leaves the block.
  function automatic sm_t sm_norm(input sm_t a);
    sm_t r;
    r      = a;
    r.sign = a.sign & (|a.mag);
    return r;
  endfunction

  // Negation is a sign flip, followed by zero normalisation.
  function automatic sm_t sm_neg(input sm_t a);
    sm_t r;
    r      = a;
    r.sign = ~a.sign;
    return sm_norm(r);
  endfunction

endpackage

// File: rtl/cordic_prerotate_addsub.sv
// Combinational sign-magnitude a +/- b via 17-bit two's complement, saturating at 0x7FFF.
module sm_addsub
  import cordic_prerotate_pkg::*;
(
  input  sm_t  a,
  input  sm_t  b,
  input  logic sub,
  output sm_t  sum_c
);

  localparam int unsigned TW = MAG_W + 2;

  logic signed [TW-1:0] a_tc;
  logic signed [TW-1:0] b_tc;
  logic signed [TW-1:0] r_tc;
  logic        [TW-1:0] r_abs;

  // Convert, add, and convert back with saturation of oversized magnitudes.
  always_comb begin
    a_tc  = $signed({2'b00, a.mag});
    b_tc  = $signed({2'b00, b.mag});
    if (a.sign)       a_tc = -a_tc;
    if (b.sign ^ sub) b_tc = -b_tc;
    r_tc  = a_tc + b_tc;
    r_abs = r_tc[TW-1] ? TW'(-r_tc) : TW'(r_tc);
    sum_c.sign = r_tc[TW-1];
    if (|r_abs[TW-1:MAG_W]) sum_c.mag = {MAG_W{1'b1}};
    else                    sum_c.mag = r_abs[MAG_W-1:0];
  end

endmodule

// File: rtl/cordic_prerotate.sv
// Two-stage conditioning pipeline: classify, then fold operands by an exact +/-90 degree rotation.
module cordic_prerotate
  import cordic_prerotate_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [W-1:0] in_x,
  input  logic [W-1:0] in_y,
  input  logic [W-1:0] in_z,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_mode,
  output logic [W-1:0] out_x,
  output logic [W-1:0] out_y,
  output logic [W-1:0] out_z,
  output logic [1:0]   out_rot,
  output logic         out_range_err
);

  logic  s1_en;
  logic  s2_en;
  logic  s1_valid;
  mode_e s1_mode;
  sm_t   s1_x;
  sm_t   s1_y;
  sm_t   s1_z;
  logic  s1_gt_half;
  logic  s1_gt_pi;
  logic  s1_xneg;
  logic  s1_yneg;

  sm_t   in_x_sm;
  sm_t   in_y_sm;
  sm_t   in_z_sm;

  sm_t   nx_c;
  sm_t   ny_c;
  sm_t   nz_c;
  sm_t   zadj_c;
  rot_e  rot_c;
  logic  err_c;
  logic  zsub_c;

  assign s2_en    = !out_valid | out_ready;
  assign s1_en    = !s1_valid | s2_en;
  assign in_ready = s1_en;

  assign in_x_sm = sm_t'(in_x);
  assign in_y_sm = sm_t'(in_y);
  assign in_z_sm = sm_t'(in_z);

  // Stage 1: capture operands with range compares and effective (non -0) signs.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
    end else if (s1_en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mode    <= mode_e'(in_mode);
        s1_x       <= in_x_sm;
        s1_y       <= in_y_sm;
        s1_z       <= in_z_sm;
        s1_gt_half <= in_z_sm.mag > HALF_PI_MAG;
        s1_gt_pi   <= in_z_sm.mag > PI_MAG;
        s1_xneg    <= in_x_sm.sign & (|in_x_sm.mag);
        s1_yneg    <= in_y_sm.sign & (|in_y_sm.mag);
      end
    end
  end

  sm_addsub u_zadj (
    .a     (s1_z),
    .b     (HALF_PI_SM),
    .sub   (zsub_c),
    .sum_c (zadj_c)
  );

  // Stage 2 decode: choose rotation direction and the swapped/negated operands.
  always_comb begin
    nx_c   = sm_norm(s1_x);
    ny_c   = sm_norm(s1_y);
    rot_c  = ROT_NONE;
    err_c  = 1'b0;
    zsub_c = 1'b0;
    if (s1_mode == MODE_ROT) begin
      if (s1_gt_pi) begin
        err_c = 1'b1;
      end else if (s1_gt_half) begin
        if (!s1_z.sign) rot_c = ROT_POS90;
        else            rot_c = ROT_NEG90;
      end
    end else if (s1_xneg) begin
      if (s1_yneg) rot_c = ROT_POS90;
      else         rot_c = ROT_NEG90;
    end
    nz_c = sm_norm(s1_z);
    if (rot_c == ROT_POS90) begin
      nx_c   = sm_neg(s1_y);
      ny_c   = sm_norm(s1_x);
      zsub_c = 1'b1;
      nz_c   = zadj_c;
    end else if (rot_c == ROT_NEG90) begin
      nx_c   = sm_norm(s1_y);
      ny_c   = sm_neg(s1_x);
      nz_c   = zadj_c;
    end
  end

  // Stage 2 register: output fields hold while the core stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid     <= 1'b0;
      out_mode      <= 1'b0;
      out_x         <= '0;
      out_y         <= '0;
      out_z         <= '0;
      out_rot       <= 2'b00;
      out_range_err <= 1'b0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_mode      <= s1_mode;
        out_x         <= nx_c;
        out_y         <= ny_c;
        out_z         <= nz_c;
        out_rot       <= rot_c;
        out_range_err <= err_c;
      end
    end
  end

endmodule

// File: tb/tb_cordic_prerotate.sv
// Directed bench for cordic_prerotate with hand-computed expected triples.
module tb_cordic_prerotate;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_mode;
  logic [15:0] in_x;
  logic [15:0] in_y;
  logic [15:0] in_z;
  logic        out_valid;
  logic        out_ready;
  logic        out_mode;
  logic [15:0] out_x;
  logic [15:0] out_y;
  logic [15:0] out_z;
  logic [1:0]  out_rot;
  logic        out_range_err;

  int checks;
  int fails;

  typedef struct packed {
    logic        mode;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic [15:0] ex;
    logic [15:0] ey;
    logic [15:0] ez;
    logic [1:0]  rot;
    logic        err;
  } vec_t;

  vec_t tv[$];

  cordic_prerotate dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_mode       (in_mode),
    .in_x          (in_x),
    .in_y          (in_y),
    .in_z          (in_z),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_mode      (out_mode),
    .out_x         (out_x),
    .out_y         (out_y),
    .out_z         (out_z),
    .out_rot       (out_rot),
    .out_range_err (out_range_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [52:0] obs();
    return {out_valid, out_mode, out_x, out_y, out_z, out_rot, out_range_err};
  endfunction

  function automatic logic [52:0] expv(input logic v, input vec_t t);
    return {v, t.mode, t.ex, t.ey, t.ez, t.rot, t.err};
  endfunction

  task automatic drive(input vec_t t);
    in_valid = 1'b1;
    in_mode  = t.mode;
    in_x     = t.x;
    in_y     = t.y;
    in_z     = t.z;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_mode = 1'b0; in_x = '0; in_y = '0; in_z = '0;
    tick(); tick();
    checks++;
    if (obs() !== 53'h0) begin
      fails++; $display("FAIL reset_outputs: got %h required %h", obs(), 53'h0);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_idle: got ready=%b valid=%b required ready=1 valid=0", in_ready, out_valid);
    end
  endtask

  task automatic test_rotation();
    tv.delete();
    tv.push_back('{1'b0, 16'h1A60, 16'h0E00, 16'h0200, 16'h1A60, 16'h0E00, 16'h0200, 2'b00, 1'b0});
    tv.push_back('{1'b0, 16'h0800, 16'h0000, 16'h1000, 16'h0000, 16'h0800, 16'h036F, 2'b01, 1'b0});
    tv.push_back('{1'b0, 16'h0800, 16'h0400, 16'h9000, 16'h0400, 16'h8800, 16'h836F, 2'b10, 1'b0});
    tv.push_back('{1'b0, 16'h0800, 16'h0400, 16'h0C91, 16'h0800, 16'h0400, 16'h0C91, 2'b00, 1'b0});
    tv.push_back('{1'b0, 16'h0800, 16'h0400, 16'h8C91, 16'h0800, 16'h0400, 16'h8C91, 2'b00, 1'b0});
    tv.push_back('{1'b0, 16'h0800, 16'h0400, 16'h1922, 16'h8400, 16'h0800, 16'h0C91, 2'b01, 1'b0});
    tv.push_back('{1'b0, 16'h0800, 16'h0400, 16'h9922, 16'h0400, 16'h8800, 16'h8C91, 2'b10, 1'b0});
    tv.push_back('{1'b0, 16'h8000, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 1'b0});
    out_ready = 1'b1;
    foreach (tv[i]) begin
      drive(tv[i]); tick();
      in_valid = 1'b0; tick();
      checks++;
      if (obs() !== expv(1'b1, tv[i])) begin
        fails++; $display("FAIL rotation[%0d]: got %h required %h", i, obs(), expv(1'b1, tv[i]));
      end
    end
    tick();
  endtask

  task automatic test_vectoring();
    tv.delete();
    tv.push_back('{1'b1, 16'h8800, 16'h0400, 16'h0000, 16'h0400, 16'h0800, 16'h0C91, 2'b10, 1'b0});
    tv.push_back('{1'b1, 16'h8800, 16'h8400, 16'h0000, 16'h0400, 16'h8800, 16'h8C91, 2'b01, 1'b0});
    tv.push_back('{1'b1, 16'h8000, 16'h8400, 16'h1234, 16'h0000, 16'h8400, 16'h1234, 2'b00, 1'b0});
    tv.push_back('{1'b1, 16'h8800, 16'h0400, 16'h7F00, 16'h0400, 16'h0800, 16'h7FFF, 2'b10, 1'b0});
    tv.push_back('{1'b1, 16'h8800, 16'h8400, 16'h0C91, 16'h0400, 16'h8800, 16'h0000, 2'b01, 1'b0});
    tv.push_back('{1'b1, 16'h0800, 16'h8000, 16'h8000, 16'h0800, 16'h0000, 16'h0000, 2'b00, 1'b0});
    tv.push_back('{1'b1, 16'h8800, 16'h8000, 16'h0000, 16'h0000, 16'h0800, 16'h0C91, 2'b10, 1'b0});
    tv.push_back('{1'b1, 16'h0400, 16'h0400, 16'h3400, 16'h0400, 16'h0400, 16'h3400, 2'b00, 1'b0});
    out_ready = 1'b1;
    foreach (tv[i]) begin
      drive(tv[i]); tick();
      in_valid = 1'b0; tick();
      checks++;
      if (obs() !== expv(1'b1, tv[i])) begin
        fails++; $display("FAIL vectoring[%0d]: got %h required %h", i, obs(), expv(1'b1, tv[i]));
      end
    end
    tick();
  endtask

  task automatic test_range();
    tv.delete();
    tv.push_back('{1'b0, 16'h1A60, 16'h0E00, 16'h3400, 16'h1A60, 16'h0E00, 16'h3400, 2'b00, 1'b1});
    tv.push_back('{1'b0, 16'h0800, 16'h0400, 16'h1923, 16'h0800, 16'h0400, 16'h1923, 2'b00, 1'b1});
    tv.push_back('{1'b0, 16'h0800, 16'h8400, 16'hB000, 16'h0800, 16'h8400, 16'hB000, 2'b00, 1'b1});
    out_ready = 1'b1;
    foreach (tv[i]) begin
      drive(tv[i]); tick();
      in_valid = 1'b0; tick();
      checks++;
      if (obs() !== expv(1'b1, tv[i])) begin
        fails++; $display("FAIL range[%0d]: got %h required %h", i, obs(), expv(1'b1, tv[i]));
      end
    end
    tick();
  endtask

  task automatic load_stream();
    tv.delete();
    tv.push_back('{1'b0, 16'h0100, 16'h0200, 16'h0300, 16'h0100, 16'h0200, 16'h0300, 2'b00, 1'b0});
    tv.push_back('{1'b0, 16'h0800, 16'h0000, 16'h1000, 16'h0000, 16'h0800, 16'h036F, 2'b01, 1'b0});
    tv.push_back('{1'b1, 16'h8800, 16'h0400, 16'h0000, 16'h0400, 16'h0800, 16'h0C91, 2'b10, 1'b0});
    tv.push_back('{1'b0, 16'h1A60, 16'h0E00, 16'h3400, 16'h1A60, 16'h0E00, 16'h3400, 2'b00, 1'b1});
  endtask

  task automatic test_back_to_back();
    load_stream();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(tv[i]); tick();
      if (i >= 1) begin
        checks++;
        if (obs() !== expv(1'b1, tv[i-1])) begin
          fails++; $display("FAIL b2b[%0d]: got %h required %h", i - 1, obs(), expv(1'b1, tv[i-1]));
        end
      end
    end
    in_valid = 1'b0; tick();
    checks++;
    if (obs() !== expv(1'b1, tv[3])) begin
      fails++; $display("FAIL b2b[3]: got %h required %h", obs(), expv(1'b1, tv[3]));
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL b2b_drain: got valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    load_stream();
    out_ready = 1'b0;
    drive(tv[0]);
    checks++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL bp_ready0: got %b required 1", in_ready);
    end
    tick();
    drive(tv[1]);
    checks++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL bp_ready1: got %b required 1", in_ready);
    end
    tick();
    drive(tv[2]);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (in_ready !== 1'b0 || obs() !== expv(1'b1, tv[0])) begin
        fails++; $display("FAIL bp_hold[%0d]: got ready=%b out=%h required ready=0 out=%h", c, in_ready, obs(), expv(1'b1, tv[0]));
      end
      if (c < 3) tick();
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (obs() !== expv(1'b1, tv[1])) begin
      fails++; $display("FAIL bp_out1: got %h required %h", obs(), expv(1'b1, tv[1]));
    end
    drive(tv[3]); tick();
    checks++;
    if (obs() !== expv(1'b1, tv[2])) begin
      fails++; $display("FAIL bp_out2: got %h required %h", obs(), expv(1'b1, tv[2]));
    end
    in_valid = 1'b0; tick();
    checks++;
    if (obs() !== expv(1'b1, tv[3])) begin
      fails++; $display("FAIL bp_out3: got %h required %h", obs(), expv(1'b1, tv[3]));
    end
    tick();
  endtask

  task automatic test_reset_mid();
    load_stream();
    out_ready = 1'b0;
    drive(tv[0]); tick();
    drive(tv[1]); tick();
    checks++;
    if (out_valid !== 1'b1) begin
      fails++; $display("FAIL rst_fill: got valid=%b required 1", out_valid);
    end
    reset = 1'b1; tick();
    checks++;
    if (obs() !== 53'h0) begin
      fails++; $display("FAIL rst_mid: got %h required %h", obs(), 53'h0);
    end
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        fails++; $display("FAIL rst_after[%0d]: got valid=%b ready=%b required valid=0 ready=1", c, out_valid, in_ready);
      end
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_rotation();
    test_vectoring();
    test_range();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/cordic_prerotate.md
Name: cordic_prerotate

Overview:
- Input conditioning stage directly upstream of the cordic core.
- Accepts operand triples (mode, x, y, z) in 16-bit sign-magnitude Q4.11 over a valid/ready handshake.
- Folds them into the core's convergence range with an exact ±90° pre-rotation and flags out-of-range angles.
- Two-stage pipeline, full throughput, back-pressure aware; outputs feed the cordic x/y/z/mode inputs directly.

Parameters:
W, 16, operand width (bit W-1 = sign, rest = magnitude)
FRAC, 11, fraction bits of magnitude
HALF_PI, 16'd3217, pi/2 magnitude in Q4.11
PI, 16'd6434, pi magnitude in Q4.11

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high; clears pipeline
in_valid  in  1  operand triple present
in_ready  out  1  stage can accept this cycle
in_mode  in  1  0 = rotation, 1 = vectoring
in_x  in  W  sign-magnitude x
in_y  in  W  sign-magnitude y
in_z  in  W  sign-magnitude angle, radians
out_valid  out  1  conditioned triple present
out_ready  in  1  cordic core accepts
out_mode  out  1  mode passed through
out_x  out  W  conditioned x
out_y  out  W  conditioned y
out_z  out  W  conditioned z
out_rot  out  2  00 none, 01 rotated +90°, 10 rotated -90°
out_range_err  out  1  rotation-mode |in_z| > PI

Behaviour:
- Reset (synchronous, active-high): s1_valid = s2_valid = 0; all out_* = 0. Reset mid-operation discards in-flight data; out_valid is low the cycle after reset is sampled.
- Handshake: s2_en = !s2_valid | out_ready; s1_en = !s1_valid | s2_en; in_ready = s1_en. Transfers occur on valid & ready at the clock edge.
- Latency: exactly 2 cycles with no stall. Throughput: 1 per cycle. Order is preserved.
- Output fields hold stable while out_valid & !out_ready.
- Stage 1 (classify), registered:
  - Compute magnitude compares |z| > HALF_PI and |z| > PI.
  - Capture sign bits of x, y, z and the mode.
- Stage 2 (pre-rotate), registered. Negation = sign-bit flip.
  - Rotation mode, |z| ≤ HALF_PI: pass through, rot = 00.
  - Rotation mode, z > +HALF_PI: x' = -y, y' = x, z' = z - HALF_PI, rot = 01.
  - Rotation mode, z < -HALF_PI: x' = y, y' = -x, z' = z + HALF_PI, rot = 10.
  - Rotation mode, |z| > PI: range_err = 1, operands pass unmodified, rot = 00.
  - Vectoring mode, x sign = 0 (incl. -0): pass through, rot = 00, range_err = 0.
  - Vectoring mode, x < 0 and y ≥ 0: x' = y, y' = -x, z' = z + HALF_PI, rot = 10.
  - Vectoring mode, x < 0 and y < 0: x' = -y, y' = x, z' = z - HALF_PI, rot = 01.
- z ± HALF_PI arithmetic:
  - Convert to 17-bit two's complement, add/subtract, convert back to sign-magnitude.
  - Result magnitude always < 2^15 for legal inputs; no saturation needed.
  - In vectoring mode with |z| near limit, the magnitude saturates at 0x7FFF.
- Negative zero: any output field with magnitude 0 is emitted with sign 0. Input -0 is treated as 0.
- Comparisons at equality: |z| == HALF_PI is not rotated; |z| == PI is not an error.

Decomposition:
- Shared header cordic_defs.vh holds W, FRAC, HALF_PI, PI, mode encodings (MODE_ROT = 0, MODE_VEC = 1) and out_rot encodings. The cordic core includes the same header.
- One sub-module, sm_addsub: combinational W-bit sign-magnitude add/subtract with negative-zero normalisation and saturation. It is instantiated once in stage 2 for z'.

Test Plan:
1. Rotation, x=0x1A60, y=0x0E00, z=0x0200 (0.25 rad), out_ready=1 -> 2 cycles later out_x/y/z identical to inputs, rot=00, range_err=0.
2. Rotation, x=0x0800, y=0x0000, z=0x1000 (+2.0) -> out_x=0x0000 (no -0), out_y=0x0800, out_z=0x036F, rot=01.
3. Rotation, x=0x0800, y=0x0400, z=0x9000 (-2.0) -> out_x=0x0400, out_y=0x8800, out_z=0x836F, rot=10.
4. Vectoring, x=0x8800 (-1.0), y=0x0400, z=0x0000 -> out_x=0x0400, out_y=0x0800, out_z=0x0C91, rot=10; same with y=0x8400 -> out_x=0x0400, out_y=0x8800, out_z=0x8C91, rot=01.
5. Rotation, z=0x3400 (|z| > PI), x=0x1A60, y=0x0E00 -> range_err=1, operands unmodified, rot=00.
6. Back-pressure: stream 4 triples back-to-back, out_ready=0 for 4 cycles -> in_ready low after 2 accepted, outputs stable, then all 4 emerge in order. Assert reset during the stall -> out_valid=0 next cycle, nothing emitted afterward.
